// File: rtl/point_halve.sv
// Sequential GF(2^7) elliptic-curve point halver (Knudsen) on y^2 + xy = x^3 + A*x^2 + b.
// Optional macro POINT_HALVE_LAMBDA_OUT_EN adds the lambda output (lambda-affine coordinate of P).
module point_halve #(
   parameter logic [6:0] A = 7'b0000001
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [13:0] point,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [13:0] half
`ifdef POINT_HALVE_LAMBDA_OUT_EN
   ,
   output logic [6:0]  lambda
`endif
);

   typedef enum logic [2:0] {IDLE, SQA, MUL1, SQB, SQRT, MUL2, DONE} state_t;

   state_t     state;
   logic [2:0] cnt;
   logic [6:0] u;
   logic [6:0] v;    // holds y of Q, then t once MUL1 has run
   logic [6:0] s;    // shared squarer register
   logic [6:0] tr;   // running trace accumulator
   logic [6:0] ht;   // half-trace lambda_hat, later lambda_P

   logic [6:0] sq_s;
   logic [6:0] tr_nx;
   logic [6:0] mul_a;
   logic [6:0] prod;
   logic [6:0] t_val;
   logic       last;

   // Squaring mod x^7+x+1 is linear: x^8 = x^2+x, x^10 = x^4+x^3, x^12 = x^6+x^5.
   function automatic logic [6:0] gf_sq(input logic [6:0] a);
      logic [6:0] r;
      r[0] = a[0];
      r[1] = a[4];
      r[2] = a[1] ^ a[4];
      r[3] = a[5];
      r[4] = a[2] ^ a[5];
      r[5] = a[6];
      r[6] = a[3] ^ a[6];
      return r;
   endfunction

   function automatic logic [6:0] mastrovito7(input logic [6:0] a, input logic [6:0] b);
      logic [12:0] p;
      p = '0;
      for (int i = 0; i < 7; i++) begin
         if (b[i]) p = p ^ (13'(a) << i);
      end
      for (int k = 12; k >= 7; k--) begin
         if (p[k]) p = p ^ (13'h083 << (k - 7));
      end
      return p[6:0];
   endfunction

   // One multiplier: u*lambda_hat in MUL1, xP*lambda_P in MUL2.
   always_comb begin
      sq_s  = gf_sq(s);
      tr_nx = tr ^ sq_s;
      mul_a = (state == MUL2) ? s : u;
      prod  = mastrovito7(mul_a, ht);
      t_val = v ^ prod;
      last  = (cnt == 3'd5);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         u     <= '0;
         v     <= '0;
         s     <= '0;
         tr    <= '0;
         ht    <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         err   <= 1'b0;
         half  <= '0;
`ifdef POINT_HALVE_LAMBDA_OUT_EN
         lambda <= '0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (load) begin
                  u     <= point[6:0];
                  v     <= point[13:7];
                  s     <= point[6:0] ^ A;
                  tr    <= point[6:0] ^ A;
                  ht    <= point[6:0] ^ A;
                  cnt   <= '0;
                  err   <= 1'b0;
                  busy  <= 1'b1;
                  state <= SQA;
               end
            end
            SQA: begin
               s   <= sq_s;
               tr  <= tr_nx;
               cnt <= cnt + 3'd1;
               if (cnt[0]) ht <= ht ^ sq_s;
               if (last) begin
                  cnt <= '0;
                  if (tr_nx != 7'd0) begin
                     err   <= 1'b1;
                     half  <= '0;
`ifdef POINT_HALVE_LAMBDA_OUT_EN
                     lambda <= '0;
`endif
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     state <= MUL1;
                  end
               end
            end
            MUL1: begin
               v     <= t_val;
               s     <= t_val;
               tr    <= t_val;
               state <= SQB;
            end
            SQB: begin
               s   <= sq_s;
               tr  <= tr_nx;
               cnt <= cnt + 3'd1;
               if (last) begin
                  cnt <= '0;
                  // Tr(t) picks which of the two half-trace roots belongs to P.
                  if (tr_nx == 7'd0) begin
                     s <= v ^ u;
                  end else begin
                     s  <= v;
                     ht <= ht ^ 7'd1;
                  end
                  state <= SQRT;
               end
            end
            SQRT: begin
               s   <= sq_s;
               cnt <= cnt + 3'd1;
               if (last) begin
                  cnt   <= '0;
                  state <= MUL2;
               end
            end
            MUL2: begin
               half  <= {prod ^ sq_s, s};
`ifdef POINT_HALVE_LAMBDA_OUT_EN
               lambda <= ht;
`endif
               done  <= 1'b1;
               state <= DONE;
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_point_halve.sv
// Bench for point_halve: random curve points P are doubled by a field-arithmetic model and
// the DUT must halve 2P back to P; also covers errors, busy rejection, back-to-back and reset.
module tb_point_halve;

   localparam logic [6:0] CURVE_A = 7'h01;
   localparam logic [6:0] CURVE_B = 7'h01;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        load = 1'b0;
   logic [13:0] point = '0;
   logic        busy;
   logic        done;
   logic        err;
   logic [13:0] half;
`ifdef POINT_HALVE_LAMBDA_OUT_EN
   logic [6:0]  lambda;
`endif

   int tests_run = 0;
   int tests_failed = 0;
   int done_cnt = 0;
   logic [13:0] pts[$];

   point_halve dut (
      .clk(clk), .rst_n(rst_n), .load(load), .point(point),
      .busy(busy), .done(done), .err(err), .half(half)
`ifdef POINT_HALVE_LAMBDA_OUT_EN
      , .lambda(lambda)
`endif
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (done) done_cnt++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference field arithmetic, bit-serial shift-and-add mod x^7+x+1.
   function automatic logic [6:0] f_mul(input logic [6:0] a, input logic [6:0] b);
      logic [6:0] r;
      logic [6:0] aa;
      r = '0;
      aa = a;
      for (int i = 0; i < 7; i++) begin
         if (b[i]) r = r ^ aa;
         aa = aa[6] ? ({aa[5:0], 1'b0} ^ 7'h03) : {aa[5:0], 1'b0};
      end
      return r;
   endfunction

   function automatic logic [6:0] f_inv(input logic [6:0] a);
      logic [6:0] r;
      r = 7'h01;
      for (int i = 0; i < 126; i++) r = f_mul(r, a);
      return r;
   endfunction

   function automatic logic [13:0] dbl(input logic [13:0] p);
      logic [6:0] x, y, lam, x3, y3;
      x   = p[6:0];
      y   = p[13:7];
      lam = x ^ f_mul(y, f_inv(x));
      x3  = f_mul(lam, lam) ^ lam ^ CURVE_A;
      y3  = f_mul(x, x) ^ f_mul(lam ^ 7'h01, x3);
      return {y3, x3};
   endfunction

   task automatic run_op(input logic [13:0] q, output logic [13:0] h, output logic e,
                         output int lat, output logic busy_after);
      point = q;
      load  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      load  = 1'b0;
      point = 14'($urandom);
      lat   = -1;
      h     = '0;
      e     = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (done) begin
            lat = k;
            break;
         end
      end
      h = half;
      e = err;
      @(posedge clk);
      @(negedge clk);
      busy_after = busy;
   endtask

   initial begin
      logic [13:0] p, q, q2, h;
      logic        e, b_after;
      int          lat, d0, first, second;

      // Points with Tr(x) = Tr(A) = 1 form the odd-order subgroup (cofactor 2).
      for (int x = 1; x < 128; x++) begin
         for (int y = 0; y < 128; y++) begin
            logic [6:0] xx, yy;
            xx = 7'(x);
            yy = 7'(y);
            if (xx[0] && ((f_mul(yy, yy) ^ f_mul(xx, yy)) ==
                (f_mul(f_mul(xx, xx), xx) ^ f_mul(CURVE_A, f_mul(xx, xx)) ^ CURVE_B)))
               pts.push_back({yy, xx});
         end
      end
      check("point_list_nonempty", 32'(pts.size() > 0), 32'd1);
      if (pts.size() == 0) begin
         $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
         $finish;
      end

      #1 rst_n = 1'b0;
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_half", 32'(half), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      run_op({7'h55, 7'h02}, h, e, lat, b_after);
      check("nh_lat", 32'(lat), 32'd6);
      check("nh_err", 32'(e), 32'd1);
      check("nh_half", 32'(h), 32'd0);
      check("nh_busy_after", 32'(b_after), 32'd0);

      run_op({7'($urandom), 7'h00}, h, e, lat, b_after);
      check("x0_lat", 32'(lat), 32'd6);
      check("x0_err", 32'(e), 32'd1);

      for (int n = 0; n < 200; n++) begin
         p = pts[$urandom_range(pts.size() - 1, 0)];
         q = dbl(p);
         run_op(q, h, e, lat, b_after);
         check("rt_lat", 32'(lat), 32'd20);
         check("rt_err", 32'(e), 32'd0);
         check("rt_half", 32'(h), 32'(p));
         check("rt_redouble", 32'(dbl(h)), 32'(q));
         check("rt_busy_after", 32'(b_after), 32'd0);
`ifdef POINT_HALVE_LAMBDA_OUT_EN
         check("rt_lambda", 32'(lambda), 32'(p[6:0] ^ f_mul(p[13:7], f_inv(p[6:0]))));
`endif
      end

      // Busy rejection: load stays high through the whole op and its DONE cycle.
      p  = pts[$urandom_range(pts.size() - 1, 0)];
      q  = dbl(p);
      q2 = dbl(pts[$urandom_range(pts.size() - 1, 0)]);
      d0 = done_cnt;
      point = q;
      load  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      point = q2;
      for (int k = 1; k <= 21; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (k == 20) begin
            check("busy_rej_done", 32'(done), 32'd1);
            check("busy_rej_half", 32'(half), 32'(p));
         end
      end
      load = 1'b0;
      repeat (25) @(negedge clk);
      check("busy_rej_pulses", 32'(done_cnt - d0), 32'd1);
      check("busy_rej_idle", 32'(busy), 32'd0);

      // Continuous load: ops start on every IDLE edge.
      point  = q;
      load   = 1'b1;
      first  = -1;
      second = -1;
      for (int k = 0; k <= 60; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (done) begin
            if (first < 0) first = k;
            else if (second < 0) second = k;
         end
      end
      load = 1'b0;
      check("b2b_first", 32'(first), 32'd20);
      check("b2b_period", 32'(second - first), 32'd22);
      repeat (30) @(negedge clk);

      // Reset in the middle of an operation.
      p = pts[$urandom_range(pts.size() - 1, 0)];
      q = dbl(p);
      point = dbl(pts[$urandom_range(pts.size() - 1, 0)]);
      load  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      load = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_half", 32'(half), 32'd0);
      check("midrst_err", 32'(err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      d0 = done_cnt;
      run_op(q, h, e, lat, b_after);
      check("midrst_lat", 32'(lat), 32'd20);
      check("midrst_half_ok", 32'(h), 32'(p));
      check("midrst_err_ok", 32'(e), 32'd0);
      check("midrst_pulses", 32'(done_cnt - d0), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
